// File: rtl/sid_pkg.sv
// Shared types and constants for the SID voice note sequencer.
package sid_pkg;

  localparam int ENV_W            = 8;
  localparam int FREQ_W           = 16;
  localparam int DUR_W            = 16;
  localparam int TICK_DIV_DEF     = 256;
  localparam int RELEASE_STEP_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ATTACK  = 2'd1,
    ST_SUSTAIN = 2'd2,
    ST_RELEASE = 2'd3
  } env_state_t;

endpackage

// File: rtl/sid_tick_gen.sv
// Envelope prescaler: counts 0..TICK_DIV-1, tick is high while the count sits
// at TICK_DIV-1. The clear input restarts the count so a new note is phase-aligned.
module sid_tick_gen
  import sid_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] count;

  assign tick = (count == CW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/sid_note_sequencer.sv
// Per-voice note sequencer: snapshots the register bank on note_start and runs
// the attack/sustain/release envelope, timed by a prescaled envelope tick.
module sid_note_sequencer
  import sid_pkg::*;
#(
  parameter int TICK_DIV     = TICK_DIV_DEF,
  parameter int RELEASE_STEP = RELEASE_STEP_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FREQ_W-1:0] sid_frequency,
  input  logic [DUR_W-1:0]  sid_duration,
  input  logic [ENV_W-1:0]  sid_attack,
  input  logic [ENV_W-1:0]  sid_sustain,
  input  logic [7:0]        sid_waveform,
  input  logic              note_start,
  input  logic              note_stop,
  output logic [FREQ_W-1:0] voice_freq,
  output logic [7:0]        voice_wave,
  output logic [ENV_W-1:0]  env_level,
  output logic              gate,
  output logic              busy,
  output logic              note_done,
  output env_state_t        state
);

  localparam logic [ENV_W-1:0] REL_STEP = ENV_W'(RELEASE_STEP);

  logic             tick;
  logic [DUR_W-1:0] sh_duration;
  logic [ENV_W-1:0] sh_attack;
  logic [ENV_W-1:0] sh_sustain;
  logic [DUR_W-1:0] dur_cnt;

  env_state_t       state_nxt;
  logic [ENV_W-1:0] env_nxt;
  logic [DUR_W-1:0] dur_nxt;
  logic             done_nxt;
  logic [ENV_W-1:0] step;
  logic [ENV_W:0]   sum;

  sid_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk   (clk),
    .rst   (rst),
    .clear (note_start),
    .tick  (tick)
  );

  // Attack of zero means "jump straight to sustain", so use the largest step.
  assign step = (sh_attack == '0) ? '1 : sh_attack;
  assign sum  = {1'b0, env_level} + {1'b0, step};

  always_comb begin
    state_nxt = state;
    env_nxt   = env_level;
    dur_nxt   = dur_cnt;
    done_nxt  = 1'b0;
    if (note_start) begin
      state_nxt = ST_ATTACK;
    end else begin
      case (state)
        ST_ATTACK: begin
          if (note_stop) begin
            state_nxt = ST_RELEASE;
          end else if (tick) begin
            // Also clamps down when a retrigger starts above the new sustain.
            if (sum >= {1'b0, sh_sustain}) begin
              env_nxt   = sh_sustain;
              state_nxt = ST_SUSTAIN;
              dur_nxt   = sh_duration;
            end else begin
              env_nxt = sum[ENV_W-1:0];
            end
          end
        end
        ST_SUSTAIN: begin
          if (note_stop) begin
            state_nxt = ST_RELEASE;
          end else if (tick && (sh_duration != '0)) begin
            dur_nxt = dur_cnt - 1'b1;
            if (dur_cnt == DUR_W'(1)) state_nxt = ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (tick) begin
            if (env_level > REL_STEP) begin
              env_nxt = env_level - REL_STEP;
            end else begin
              env_nxt   = '0;
              state_nxt = ST_IDLE;
              done_nxt  = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      env_level   <= '0;
      dur_cnt     <= '0;
      note_done   <= 1'b0;
      gate        <= 1'b0;
      busy        <= 1'b0;
      voice_freq  <= '0;
      voice_wave  <= '0;
      sh_duration <= '0;
      sh_attack   <= '0;
      sh_sustain  <= '0;
    end else begin
      state     <= state_nxt;
      env_level <= env_nxt;
      dur_cnt   <= dur_nxt;
      note_done <= done_nxt;
      gate      <= (state_nxt == ST_ATTACK) || (state_nxt == ST_SUSTAIN);
      busy      <= (state_nxt != ST_IDLE);
      if (note_start) begin
        voice_freq  <= sid_frequency;
        voice_wave  <= sid_waveform;
        sh_duration <= sid_duration;
        sh_attack   <= sid_attack;
        sh_sustain  <= sid_sustain;
      end
    end
  end

endmodule

// File: doc/sid_note_sequencer.md
# sid_note_sequencer

Per-voice note sequencer for the SID voice. It sits between the SPI register bank outputs (`sid_frequency`, `sid_duration`, `sid_attack`, `sid_sustain`, `sid_waveform`) and the oscillator/DAC path. On a start request it snapshots the register values, drives gate and envelope level through an attack/sustain/release state machine, and times each phase with a prescaled envelope tick. SPI writes during a note therefore never glitch the sounding voice.

## Interface
- `TICK_DIV`, 256: clk cycles per envelope tick (≥2).
- `RELEASE_STEP`, 16: envelope decrement per tick in RELEASE (1–255).
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `sid_frequency`  in  16  oscillator frequency word from the register bank.
- `sid_duration`  in  16  sustain length in ticks; 0 = hold until `note_stop`.
- `sid_attack`  in  8  envelope increment per tick in ATTACK; 0 = jump immediately.
- `sid_sustain`  in  8  sustain envelope level.
- `sid_waveform`  in  8  waveform select.
- `note_start`  in  1  one-cycle pulse: start or retrigger a note.
- `note_stop`  in  1  one-cycle pulse: force release.
- `voice_freq`  out  16  latched frequency.
- `voice_wave`  out  8  latched waveform.
- `env_level`  out  8  envelope amplitude.
- `gate`  out  1  high in ATTACK or SUSTAIN.
- `busy`  out  1  high whenever state ≠ IDLE.
- `note_done`  out  1  one-cycle pulse on the RELEASE→IDLE transition.

## Operation
- States: IDLE, ATTACK, SUSTAIN, RELEASE.
- `note_start` in any state:
  - Latch all five inputs into shadow registers.
  - Enter ATTACK.
  - Clear the prescaler.
  - Keep the current `env_level`; a retrigger does not zero it.
- Prescaler: counts 0..TICK_DIV−1 and asserts tick when the count is TICK_DIV−1. It is free-running except for the clear on `note_start`.
- ATTACK, on each tick:
  - `env_level` ← min(env + step, shadow sustain), computed 9-bit wide, where step = 255 if shadow attack = 0, else shadow attack.
  - If the result equals sustain, go to SUSTAIN and load the duration counter from shadow duration.
  - If env > sustain at retrigger, the first tick clamps env down to sustain.
- SUSTAIN:
  - If shadow duration ≠ 0, decrement the counter each tick. On the tick where the counter = 1, go to RELEASE.
  - If shadow duration = 0, hold indefinitely.
- RELEASE, on each tick: env ← (env > RELEASE_STEP) ? env − RELEASE_STEP : 0. When the result is 0, go to IDLE and pulse `note_done`.
- `note_stop` in ATTACK or SUSTAIN goes to RELEASE; the prescaler is not cleared. `note_stop` in RELEASE or IDLE is ignored.
- Simultaneous `note_start` and `note_stop`: start wins.
- Simultaneous `note_start` and tick: start wins; that tick is discarded.
- Input register changes outside a `note_start` cycle have no effect on outputs.

## Timing
- All outputs are registered.
- Reset values:
  - `state` = IDLE.
  - `voice_freq` = 0, `voice_wave` = 0, `env_level` = 0.
  - `gate` = 0, `busy` = 0, `note_done` = 0.
  - Prescaler and duration counter = 0.
- `note_start` sampled at edge N: `voice_freq`, `voice_wave`, `gate` = 1 and `busy` = 1 are all visible after edge N.
- The first envelope update occurs exactly TICK_DIV cycles after the start edge.
- `env_level` and state change on the same edge as the tick.
- `note_stop` at edge N: `gate` = 0 after edge N.
- `note_done` is high for exactly one cycle, coincident with `busy` falling.
- `rst` mid-note returns to reset values on the next edge; no `note_done` is produced.

## Structure
- Shared package `sid_pkg` holds:
  - The state enum `env_state_t` (IDLE/ATTACK/SUSTAIN/RELEASE).
  - `ENV_W` = 8 and `FREQ_W` = 16.
  - The default `TICK_DIV` and `RELEASE_STEP` constants.
- One sub-module, `sid_tick_gen`: a TICK_DIV prescaler with a synchronous clear input and a tick output.
- The FSM, shadow registers, envelope arithmetic and duration counter live in `sid_note_sequencer`.

## Test plan
Parameters for all scenarios: TICK_DIV = 4, RELEASE_STEP = 16.
- Full note: attack=64, sustain=200, duration=3, start → env 64/128/192/200 on ticks 1–4, SUSTAIN for 3 ticks, then release 184…8, 0 after 13 ticks. `note_done` is a single pulse and `busy` drops in the same cycle.
- Snapshot: start with freq=0x1234, then write freq=0xBEEF mid-note → `voice_freq` stays 0x1234 until the next `note_start`.
- Attack=0, sustain=100 → env = 100 on the first tick; duration=0 holds SUSTAIN for 1000 cycles; `note_stop` → `gate` = 0 next edge, release reaches 0 after 7 ticks.
- Retrigger during RELEASE at env=120 with sustain=80 → ATTACK; the first tick clamps env to 80, then SUSTAIN; no `note_done` from the aborted release.
- `note_start` and `note_stop` in the same cycle → ATTACK and `gate` = 1. `rst` asserted mid-SUSTAIN → all outputs 0 next edge, `note_done` stays 0.
